// File: rtl/glyph_scan_renderer_pkg.sv
// Shared glyph geometry, pixel colour type and blink state encoding for the glyph scan renderer.
package glyph_pkg;
    localparam int GLYPH_W  = 8;
    localparam int GLYPH_H  = 16;
    localparam int GLYPH_AW = 7;

    typedef logic [15:0] rgb565_t;
    typedef enum logic {SHOW, HIDE} blink_state_t;
endpackage

// File: rtl/glyph_scan_renderer_if.sv
// Raster-in / pixel-out bundle of the glyph scan renderer, including the external glyph ROM port.
interface glyph_scan_renderer_if;
    import glyph_pkg::*;

    logic [9:0]          pix_x;
    logic [9:0]          pix_y;
    logic                pix_de;
    logic                hsync_in;
    logic                vsync_in;
    logic                blink_en;
    logic [GLYPH_AW-1:0] rom_addr;
    logic                rom_q;
    rgb565_t             rgb_out;
    logic                de_out;
    logic                hsync_out;
    logic                vsync_out;

    modport master (
        input  pix_x, pix_y, pix_de, hsync_in, vsync_in, blink_en, rom_q,
        output rom_addr, rgb_out, de_out, hsync_out, vsync_out
    );

    modport slave (
        output pix_x, pix_y, pix_de, hsync_in, vsync_in, blink_en, rom_q,
        input  rom_addr, rgb_out, de_out, hsync_out, vsync_out
    );
endinterface

// File: rtl/glyph_scan_renderer_blink_ctrl.sv
// Frame-based blink controller: vsync rising-edge detect, frame counter and SHOW/HIDE state machine.
module glyph_blink_ctrl
    import glyph_pkg::*;
#(
    parameter int BLINK_FRAMES = 30
) (
    input  logic clock,
    input  logic reset,
    input  logic vsync_in,
    input  logic blink_en,
    output logic visible
);
    localparam int            CW   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CW-1:0] LAST = CW'(BLINK_FRAMES - 1);

    logic          vsync_d;
    logic [CW-1:0] frame_cnt;
    blink_state_t  state;

    // State only moves on a frame boundary, so a glyph never changes mid-frame.
    always_ff @(posedge clock) begin
        if (reset) begin
            vsync_d   <= 1'b0;
            frame_cnt <= '0;
            state     <= SHOW;
        end else begin
            vsync_d <= vsync_in;
            if (vsync_in && !vsync_d) begin
                if (!blink_en) begin
                    frame_cnt <= '0;
                    state     <= SHOW;
                end else if (frame_cnt == LAST) begin
                    frame_cnt <= '0;
                    state     <= (state == SHOW) ? HIDE : SHOW;
                end else begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end
        end
    end

    assign visible = (state == SHOW);
endmodule

// File: rtl/glyph_scan_renderer.sv
// Glyph box renderer: raster position -> glyph ROM address -> RGB565, 3-cycle pipeline with aligned DE/syncs.
// Optional outline of the glyph box enabled by defining GLYPH_BORDER_EN.
module glyph_scan_renderer
    import glyph_pkg::*;
#(
    parameter int      GLYPH_X0     = 160,
    parameter int      GLYPH_Y0     = 120,
    parameter int      SCALE_LOG2   = 0,
    parameter rgb565_t FG_COLOR     = 16'hFFFF,
    parameter rgb565_t BG_COLOR     = 16'h0000,
    parameter int      BLINK_FRAMES = 30
) (
    input logic                   clock,
    input logic                   reset,
    glyph_scan_renderer_if.master bus
);
    localparam logic [10:0] X0    = 11'(GLYPH_X0);
    localparam logic [10:0] Y0    = 11'(GLYPH_Y0);
    localparam logic [10:0] BOX_W = 11'(GLYPH_W << SCALE_LOG2);
    localparam logic [10:0] BOX_H = 11'(GLYPH_H << SCALE_LOG2);

    function automatic rgb565_t pixel_color(input logic de, input logic hit, input logic force_fg);
        if (!de)                 return '0;
        else if (hit || force_fg) return FG_COLOR;
        else                     return BG_COLOR;
    endfunction

    logic       visible;
    logic [10:0] dx, dy;
    logic       in_box;
    logic [2:0] col;
    logic [3:0] row;

    glyph_blink_ctrl #(.BLINK_FRAMES(BLINK_FRAMES)) u_blink (
        .clock    (clock),
        .reset    (reset),
        .vsync_in (bus.vsync_in),
        .blink_en (bus.blink_en),
        .visible  (visible)
    );

    // 11-bit unsigned offsets: positions left/above the box wrap to huge values and fall outside.
    assign dx     = {1'b0, bus.pix_x} - X0;
    assign dy     = {1'b0, bus.pix_y} - Y0;
    assign in_box = bus.pix_de && (dx < BOX_W) && (dy < BOX_H);
    assign col    = 3'(dx >> SCALE_LOG2);
    assign row    = 4'(dy >> SCALE_LOG2);

    logic in_box_p1, de_p1, hs_p1, vs_p1, vis_p1;
    logic in_box_p2, de_p2, hs_p2, vs_p2, vis_p2;
`ifdef GLYPH_BORDER_EN
    logic border_p1, border_p2;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            in_box_p1     <= 1'b0;
            de_p1         <= 1'b0;
            hs_p1         <= 1'b0;
            vs_p1         <= 1'b0;
            vis_p1        <= 1'b0;
            in_box_p2     <= 1'b0;
            de_p2         <= 1'b0;
            hs_p2         <= 1'b0;
            vs_p2         <= 1'b0;
            vis_p2        <= 1'b0;
            bus.rom_addr  <= '0;
            bus.rgb_out   <= '0;
            bus.de_out    <= 1'b0;
            bus.hsync_out <= 1'b0;
            bus.vsync_out <= 1'b0;
`ifdef GLYPH_BORDER_EN
            border_p1     <= 1'b0;
            border_p2     <= 1'b0;
`endif
        end else begin
            // stage 1: box decode and ROM address
            in_box_p1 <= in_box;
            de_p1     <= bus.pix_de;
            hs_p1     <= bus.hsync_in;
            vs_p1     <= bus.vsync_in;
            vis_p1    <= visible;
            if (in_box) bus.rom_addr <= {row, col};
`ifdef GLYPH_BORDER_EN
            border_p1 <= in_box && (col == 3'd0 || col == 3'(GLYPH_W - 1) ||
                                    row == 4'd0 || row == 4'(GLYPH_H - 1));
`endif
            // stage 2: wait alongside the ROM read
            in_box_p2 <= in_box_p1;
            de_p2     <= de_p1;
            hs_p2     <= hs_p1;
            vs_p2     <= vs_p1;
            vis_p2    <= vis_p1;
`ifdef GLYPH_BORDER_EN
            border_p2 <= border_p1;
`endif
            // stage 3: colour the pixel using the returned ROM bit
`ifdef GLYPH_BORDER_EN
            bus.rgb_out <= pixel_color(de_p2, in_box_p2 && vis_p2 && bus.rom_q, border_p2);
`else
            bus.rgb_out <= pixel_color(de_p2, in_box_p2 && vis_p2 && bus.rom_q, 1'b0);
`endif
            bus.de_out    <= de_p2;
            bus.hsync_out <= hs_p2;
            bus.vsync_out <= vs_p2;
        end
    end
endmodule

// File: tb/tb_glyph_scan_renderer.sv
// Scoreboard bench for glyph_scan_renderer: one unscaled blinking instance and one 2x-scaled instance.
module tb_glyph_scan_renderer;
    import glyph_pkg::*;

`ifdef GLYPH_BORDER_EN
    localparam bit BORDER = 1'b1;
`else
    localparam bit BORDER = 1'b0;
`endif
    localparam rgb565_t FG0 = 16'hFFFF;
    localparam rgb565_t BG0 = 16'h0000;
    localparam rgb565_t FG1 = 16'hF800;
    localparam rgb565_t BG1 = 16'h001F;
    localparam rgb565_t BD0 = BORDER ? FG0 : BG0;
    localparam rgb565_t BD1 = BORDER ? FG1 : BG1;

    typedef struct {
        rgb565_t rgb;
        logic    hs;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    glyph_scan_renderer_if b0();
    glyph_scan_renderer_if b1();

    glyph_scan_renderer #(.GLYPH_X0(160), .GLYPH_Y0(120), .SCALE_LOG2(0),
        .FG_COLOR(FG0), .BG_COLOR(BG0), .BLINK_FRAMES(2))
        dut0 (.clock(clk), .reset(rst), .bus(b0.master));

    glyph_scan_renderer #(.GLYPH_X0(160), .GLYPH_Y0(120), .SCALE_LOG2(1),
        .FG_COLOR(FG1), .BG_COLOR(BG1), .BLINK_FRAMES(30))
        dut1 (.clock(clk), .reset(rst), .bus(b1.master));

    // "7" glyph ROM: addresses 25..30 hold ones, 1-cycle registered read
    always @(posedge clk) begin
        b0.rom_q <= (b0.rom_addr >= 7'd25) && (b0.rom_addr <= 7'd30);
        b1.rom_q <= (b1.rom_addr >= 7'd25) && (b1.rom_addr <= 7'd30);
    end

    exp_t q0[$];
    exp_t q1[$];
    int compared   = 0;
    int mismatched = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always begin : mon0
        exp_t e;
        @(negedge clk);
        if (!rst) begin
            if (b0.de_out === 1'b1) begin
                if (q0.size() == 0) begin
                    compared++; mismatched++;
                    $display("FAIL dut0_unexpected_pixel: got rgb %0h, expected no pixel", b0.rgb_out);
                end else begin
                    e = q0.pop_front();
                    check("dut0_rgb", 32'(b0.rgb_out), 32'(e.rgb));
                    check("dut0_hsync_out", 32'(b0.hsync_out), 32'(e.hs));
                end
            end else begin
                check("dut0_blank_rgb", 32'(b0.rgb_out), 32'h0);
            end
        end
    end

    always begin : mon1
        exp_t e;
        @(negedge clk);
        if (!rst) begin
            if (b1.de_out === 1'b1) begin
                if (q1.size() == 0) begin
                    compared++; mismatched++;
                    $display("FAIL dut1_unexpected_pixel: got rgb %0h, expected no pixel", b1.rgb_out);
                end else begin
                    e = q1.pop_front();
                    check("dut1_rgb", 32'(b1.rgb_out), 32'(e.rgb));
                    check("dut1_hsync_out", 32'(b1.hsync_out), 32'(e.hs));
                end
            end else begin
                check("dut1_blank_rgb", 32'(b1.rgb_out), 32'h0);
            end
        end
    end

    task automatic set_in(input int x, input int y, input logic de, input logic hs, input logic vs);
        b0.pix_x = 10'(x);  b1.pix_x = 10'(x);
        b0.pix_y = 10'(y);  b1.pix_y = 10'(y);
        b0.pix_de = de;     b1.pix_de = de;
        b0.hsync_in = hs;   b1.hsync_in = hs;
        b0.vsync_in = vs;   b1.vsync_in = vs;
    endtask

    task automatic set_blink(input logic en);
        b0.blink_en = en;
        b1.blink_en = en;
    endtask

    // One pixel per cycle; a negative address means "do not check rom_addr".
    task automatic pix(input int x, input int y, input logic de, input logic hs,
                       input rgb565_t e0, input rgb565_t e1, input int a0, input int a1);
        exp_t t;
        set_in(x, y, de, hs, 1'b0);
        if (de) begin
            t.hs = hs;
            t.rgb = e0; q0.push_back(t);
            t.rgb = e1; q1.push_back(t);
        end
        @(posedge clk); #1;
        if (a0 >= 0) check("dut0_rom_addr", 32'(b0.rom_addr), 32'(a0));
        if (a1 >= 0) check("dut1_rom_addr", 32'(b1.rom_addr), 32'(a1));
    endtask

    task automatic idle(input int n);
        set_in(0, 0, 1'b0, 1'b0, 1'b0);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic frame_edge();
        set_in(0, 0, 1'b0, 1'b0, 1'b1);
        @(posedge clk); #1;
        set_in(0, 0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk); #1;
        check("dut0_vsync_out", 32'(b0.vsync_out), 32'h1);
        check("dut1_vsync_out", 32'(b1.vsync_out), 32'h1);
    endtask

    initial begin
        set_blink(1'b0);
        set_in(161, 123, 1'b1, 1'b1, 1'b1);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_rom_addr", 32'(b0.rom_addr), 32'h0);
        check("reset_rgb_out", 32'(b0.rgb_out), 32'h0);
        check("reset_de_out", 32'(b0.de_out), 32'h0);
        check("reset_hsync_out", 32'(b0.hsync_out), 32'h0);
        check("reset_vsync_out", 32'(b0.vsync_out), 32'h0);
        check("reset_dut1_rgb_out", 32'(b1.rgb_out), 32'h0);
        set_in(0, 0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        idle(4);

        // Geometry: box edges, address hold outside the box, scaled mapping.
        pix(161, 123, 1'b1, 1'b0, FG0, BD1,  25,  8);
        pix(159, 123, 1'b1, 1'b0, BG0, BG1,  25,  8);
        pix(168, 123, 1'b1, 1'b0, BG0, BG1,  25, 12);
        pix(167, 123, 1'b1, 1'b0, BD0, BG1,  31, 11);
        pix(166, 123, 1'b1, 1'b1, FG0, BG1,  30, 11);
        pix(163, 127, 1'b1, 1'b0, BG0, FG1,  59, 25);
        pix(175, 127, 1'b1, 1'b0, BG0, BD1,  59, 31);
        pix(176, 127, 1'b1, 1'b0, BG0, BG1,  59, 31);
        pix(172, 126, 1'b1, 1'b0, BG0, FG1,  59, 30);
        pix(161, 135, 1'b1, 1'b0, BD0, BD1, 121, 56);
        pix(161, 136, 1'b1, 1'b0, BG0, BD1, 121, 64);
        pix(161, 123, 1'b0, 1'b0, BG0, BG1, 121, 64);
        pix(161,   0, 1'b1, 1'b0, BG0, BG1, 121, 64);
        pix(160, 130, 1'b1, 1'b0, BD0, BD1,  80, 40);
        idle(4);

        // Blinking with a two-frame half-period on the unscaled instance.
        set_blink(1'b1);
        frame_edge(); pix(161, 123, 1'b1, 1'b0, FG0, BD1, 25, 8);
        frame_edge(); pix(161, 123, 1'b1, 1'b0, BG0, BD1, 25, 8);
        pix(160, 130, 1'b1, 1'b0, BD0, BD1, 80, 40);
        frame_edge(); pix(161, 123, 1'b1, 1'b0, BG0, BD1, 25, 8);
        frame_edge(); pix(161, 123, 1'b1, 1'b0, FG0, BD1, 25, 8);
        frame_edge(); frame_edge();
        pix(161, 123, 1'b1, 1'b0, BG0, BD1, 25, 8);
        set_blink(1'b0);
        pix(161, 123, 1'b1, 1'b0, BG0, BD1, 25, 8);
        idle(3);
        pix(161, 123, 1'b1, 1'b0, BG0, BD1, 25, 8);
        frame_edge(); pix(161, 123, 1'b1, 1'b0, FG0, BD1, 25, 8);
        frame_edge(); pix(161, 123, 1'b1, 1'b0, FG0, BD1, 25, 8);
        idle(4);

        // Re-enter HIDE, then reset with a pixel in flight: it must vanish and blink returns to SHOW.
        set_blink(1'b1);
        frame_edge(); frame_edge();
        pix(161, 123, 1'b1, 1'b0, BG0, BD1, 25, 8);
        idle(4);
        pix(166, 123, 1'b1, 1'b0, BG0, BG1, 30, 11);
        rst = 1'b1;
        q0.delete();
        q1.delete();
        set_in(0, 0, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        check("flush_rom_addr", 32'(b0.rom_addr), 32'h0);
        idle(5);
        pix(161, 123, 1'b1, 1'b0, FG0, BD1, 25, 8);
        idle(2);

        for (int i = 0; i < 50 && (q0.size() != 0 || q1.size() != 0); i++) @(posedge clk);
        if (q0.size() != 0 || q1.size() != 0) begin
            compared++; mismatched++;
            $display("FAIL drain_timeout: got %0d/%0d pending pixels, expected 0", q0.size(), q1.size());
        end
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
